mdu_ctrl: RTL and testbench

- Sequencing controller for the iterative multiply/divide unit (MDU) of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a WIDTH-cycle radix-2 engine.
- Drives `Stall_MDU` into the hazard logic so that HI/LO readers and younger MDU ops hold in ID while the unit is busy.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_datapath.sv | 99 +++++++++
 rtl/mdu_ctrl.sv | 97 +++++++++
 tb/tb_mdu_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
//============================================================================
// mdu_pkg : shared op encodings, FSM states and constants for the MDU  rev 1.0
//============================================================================
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Quotient magnitude for a zero divisor; the low WIDTH bits are used.
  localparam logic [63:0] DIV0_QUO = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic is_calc_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_datapath.sv
`default_nettype none
//============================================================================
// mdu_datapath : radix-2 shift-add multiply / restoring divide, sign fix rev 1.0
//============================================================================
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] m;
  logic             is_div;
  logic             neg_lo;
  logic             neg_rem;
  logic             div0;

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Magnitudes: -2^(WIDTH-1) negates to itself, which is the correct unsigned value.
  assign sgn   = is_signed_op(op);
  assign a_mag = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH-1:0] mul_qr_n;

  // Add multiplicand when the multiplier LSB is set, then shift {carry,acc,qr} right.
  assign mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign mul_acc_n = mul_sum[WIDTH:1];
  assign mul_qr_n  = {mul_sum[0], qr[WIDTH-1:1]};

  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_n;
  logic [WIDTH-1:0] div_qr_n;

  // When the trial subtraction succeeds the true difference is below m, so WIDTH bits suffice.
  assign div_sh    = {acc, qr[WIDTH-1]};
  assign div_ge    = (div_sh >= {1'b0, m});
  assign div_diff  = div_sh[WIDTH-1:0] - m;
  assign div_acc_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_qr_n  = {qr[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      qr      <= '0;
      m       <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (load) begin
      acc     <= '0;
      qr      <= is_div_op(op) ? a_mag : b_mag;
      m       <= is_div_op(op) ? b_mag : a_mag;
      is_div  <= is_div_op(op);
      neg_lo  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem <= sgn & a[WIDTH-1];
      div0    <= (b == '0);
    end else if (step) begin
      acc <= is_div ? div_acc_n : mul_acc_n;
      qr  <= is_div ? div_qr_n  : mul_qr_n;
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod     = {acc, qr};
  assign prod_fix = neg_lo ? (~prod + (2*WIDTH)'(1)) : prod;
  assign quo      = div0 ? DIV0_QUO[WIDTH-1:0] : qr;
  assign quo_fix  = neg_lo ? (~quo + WIDTH'(1)) : quo;
  assign rem_fix  = neg_rem ? (~acc + WIDTH'(1)) : acc;

  assign res_hi = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quo_fix : prod_fix[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
//============================================================================
// mdu_ctrl : MDU sequencer, HI/LO owner and stall request generation rev 1.0
//============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_EX,
  input  logic [2:0]       op_EX,
  input  logic [WIDTH-1:0] a_EX,
  input  logic [WIDTH-1:0] b_EX,
  input  logic             rd_hilo_ID,
  input  logic             mdu_op_ID,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             Stall_MDU
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             calc_start;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign calc_start = start_EX & is_calc_op(op_EX);
  assign load       = (state == ST_IDLE) & calc_start;
  assign step       = (state == ST_CALC);

  // Covers the start cycle too, so a reader in ID never slips past a fresh MULT/DIV.
  assign Stall_MDU  = (busy | calc_start) & (rd_hilo_ID | mdu_op_ID);

  mdu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (op_EX),
    .a      (a_EX),
    .b      (b_EX),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (calc_start) begin
            state <= ST_CALC;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
          end else if (start_EX && (op_EX == MDU_MTHI)) begin
            hi <= a_EX;
          end else if (start_EX && (op_EX == MDU_MTLO)) begin
            lo <= a_EX;
          end
        end
        ST_CALC: begin
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
//============================================================================
// tb_mdu_ctrl : self-checking bench for mdu_ctrl (WIDTH = 32)        rev 1.0
//============================================================================
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_EX;
  logic [2:0]  op_EX;
  logic [31:0] a_EX;
  logic [31:0] b_EX;
  logic        rd_hilo_ID;
  logic        mdu_op_ID;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        Stall_MDU;

  int tests = 0;
  int fails = 0;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_EX   (start_EX),
    .op_EX      (op_EX),
    .a_EX       (a_EX),
    .b_EX       (b_EX),
    .rd_hilo_ID (rd_hilo_ID),
    .mdu_op_ID  (mdu_op_ID),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .Stall_MDU  (Stall_MDU)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      MDU_MULTU: return ux * uy;
      MDU_MULT:  return sx * sy;
      MDU_DIVU:  return (y == 32'h0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      MDU_DIV: begin
        if (y == 32'h0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MDU_MTHI:  return {x, cur[31:0]};
      MDU_MTLO:  return {cur[63:32], x};
      default:   return cur;
    endcase
  endfunction

  // Issue one op in EX for a single cycle; n = edges after the start edge until busy drops.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
    @(negedge clk);
    start_EX = 1'b1;
    op_EX    = o;
    a_EX     = x;
    b_EX     = y;
    @(posedge clk);
    #1;
    start_EX = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int stall_cnt;
    bit done;
    logic [63:0] st;
    logic [2:0]  o;
    logic [31:0] x, y;

    tbl[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    tbl[1]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    tbl[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[3]  = '{MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 33};
    tbl[4]  = '{MDU_DIV,   32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 33};
    tbl[5]  = '{MDU_DIVU,  32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 33};
    tbl[6]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    tbl[7]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
    tbl[8]  = '{MDU_MULT,  32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    tbl[9]  = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    tbl[10] = '{MDU_MTLO,  32'hCAFE_BABE, 32'h0000_0000, 32'h0000_0001, 32'hCAFE_BABE, 0};
    tbl[11] = '{MDU_MTHI,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_BABE, 0};
    tbl[12] = '{MDU_DIVU,  32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 33};
    tbl[13] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33};

    rst = 1'b1; start_EX = 1'b0; op_EX = 3'd0; a_EX = '0; b_EX = '0;
    rd_hilo_ID = 1'b0; mdu_op_ID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi/lo", {hi, lo}, 64'h0);
    check("reset busy/stall", {62'h0, busy, Stall_MDU}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, n);
      check($sformatf("vec%0d hi/lo", i), {hi, lo}, {tbl[i].hi, tbl[i].lo});
      check($sformatf("vec%0d cycles", i), 64'(n), 64'(tbl[i].cyc));
    end

    // Idle reader: no stall, sees current HI/LO.
    @(negedge clk);
    rd_hilo_ID = 1'b1;
    #1;
    check("idle read stall", {63'h0, Stall_MDU}, 64'h0);
    check("idle read value", {hi, lo}, 64'h0000_0001_0000_0000);

    // MULT with MFLO in ID; a later MULTU and MTLO during busy must be ignored.
    stall_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start_EX = 1'b1; op_EX = MDU_MULT; a_EX = 32'hFFFF_FFFD; b_EX = 32'd7;
      end else if (c == 5) begin
        start_EX = 1'b1; op_EX = MDU_MULTU; a_EX = 32'd5; b_EX = 32'd9;
      end else if (c == 7) begin
        start_EX = 1'b1; op_EX = MDU_MTLO; a_EX = 32'hDEAD_BEEF;
      end else begin
        start_EX = 1'b0;
      end
      #1;
      if (Stall_MDU) stall_cnt++;
      else begin
        done = 1'b1;
        check("stall release result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      end
    end
    check("stall length", 64'(stall_cnt), 64'd34);
    check("stall released", {63'h0, done}, 64'h1);
    rd_hilo_ID = 1'b0;

    // Reset in the 10th CALC cycle discards the operation.
    @(negedge clk);
    start_EX = 1'b1; op_EX = MDU_MULTU; a_EX = 32'hFFFF_FFFF; b_EX = 32'd3;
    mdu_op_ID = 1'b1;
    @(posedge clk);
    #1;
    start_EX = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("stall on mdu_op_ID", {62'h0, busy, Stall_MDU}, 64'h3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid-op reset hi/lo", {hi, lo}, 64'h0);
    check("mid-op reset busy/stall", {62'h0, busy, Stall_MDU}, 64'h0);
    mdu_op_ID = 1'b0;
    run_op(MDU_MTHI, 32'h0000_1234, 32'h0, n);
    check("mthi after reset", {hi, lo}, 64'h0000_1234_0000_0000);
    check("mthi busy", {32'h0, 31'h0, busy, n}, 64'h0);

    st = {hi == 32'h0000_1234 ? 32'h0000_1234 : 32'h0000_1234, 32'h0};
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      x = pick();
      y = pick();
      st = model(o, x, y, st);
      run_op(o, x, y, n);
      check($sformatf("rand%0d op%0d %h,%h", i, o, x, y), {hi, lo}, st);
      check($sformatf("rand%0d cycles", i), 64'(n), (o <= MDU_DIVU) ? 64'd33 : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
